// File: rtl/loader_pkg.sv
// Shared types and constants for the stream-to-memory loader and the memory_ip wrapper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

    localparam int BYTE_W       = 8;
    localparam int DEF_ADDR_W   = 9;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_READ_LAT = 2;
    // Wide enough for any practical RAM read latency
    localparam int LAT_W        = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RECV_HI,
        S_RECV_LO,
        S_WR_SETUP,
        S_WR_STROBE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_CMP,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Byte stream in, single-port RAM bus out, bundled for the loader.
// Latency: n/a (wires only).
// Backpressure: in_ready from the loader throttles the byte source.
interface mem_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic [BYTE_W-1:0] in_byte;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              mem_rden;
    logic [DATA_W-1:0] mem_q;

    // Loader side
    modport master (
        input  in_valid, in_byte, mem_q,
        output in_ready, mem_address, mem_data, mem_wren, mem_rden
    );

    // Byte source and RAM side
    modport slave (
        output in_valid, in_byte, mem_q,
        input  in_ready, mem_address, mem_data, mem_wren, mem_rden
    );
endinterface

// File: rtl/mem_loader_byte_packer.sv
// Pairs two stream bytes (high first) into one 16-bit word.
// Latency: word presented combinationally in the cycle the low byte transfers.
// Backpressure: transfers only when the loader's registered ready is high.
module byte_packer
    import loader_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                ready_i,
    input  logic                lo_phase_i,
    input  logic                in_valid_i,
    input  logic [BYTE_W-1:0]   in_byte_i,
    output logic                fire_o,
    output logic                word_vld_o,
    output logic [2*BYTE_W-1:0] word_o
);
    logic [BYTE_W-1:0] hi_q;

    assign fire_o     = in_valid_i && ready_i;
    assign word_vld_o = fire_o && lo_phase_i;
    assign word_o     = {hi_q, in_byte_i};

    // Hold the high byte until its partner arrives
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
        end else if (fire_o && !lo_phase_i) begin
            hi_q <= in_byte_i;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Loads N stream words into RAM from BASE_ADDR, reads them back and checks an additive checksum.
// Latency: 4 clocks per word to write plus READ_LAT+1 per word to verify, after the start clock.
// Backpressure: in_ready only in the receive states; in_valid low stalls indefinitely.
module mem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BASE_ADDR = 1,
    parameter int READ_LAT  = DEF_READ_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    mem_loader_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [LAT_W-1:0]  WAIT_LD = (READ_LAT > 1) ? LAT_W'(READ_LAT - 2) : '0;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wcnt_q;
    logic [ADDR_W-1:0] n_q;
    logic [DATA_W-1:0] vsum_q;
    logic [LAT_W-1:0]  wait_q;
    logic              in_ready_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              mem_wren_q;
    logic              mem_rden_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [DATA_W-1:0] checksum_q;

    logic              fire;
    logic              word_vld;
    logic [DATA_W-1:0] word;
    logic [ADDR_W:0]   end_excl_d;
    logic              range_bad_d;
    logic [ADDR_W-1:0] wcnt_d;
    logic              last_d;
    logic [DATA_W-1:0] vsum_d;

    // The one-past-last address must fit in the counter, so the post-write
    // increment can never wrap back onto low addresses.
    assign end_excl_d  = {1'b0, BASE_A} + {1'b0, word_count};
    assign range_bad_d = (word_count == '0) || end_excl_d[ADDR_W];
    assign wcnt_d      = wcnt_q + 1'b1;
    assign last_d      = (wcnt_d == n_q);
    assign vsum_d      = vsum_q + bus.mem_q;

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .ready_i    (in_ready_q),
        .lo_phase_i (state_q == S_RECV_LO),
        .in_valid_i (bus.in_valid),
        .in_byte_i  (bus.in_byte),
        .fire_o     (fire),
        .word_vld_o (word_vld),
        .word_o     (word)
    );

    // Main sequencer: receive, write, read back, compare; all outputs registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wcnt_q        <= '0;
            n_q           <= '0;
            vsum_q        <= '0;
            wait_q        <= '0;
            in_ready_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            mem_rden_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            checksum_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        error_q <= range_bad_d;
                        if (range_bad_d) begin
                            state_q <= S_ERROR;
                        end else begin
                            checksum_q <= '0;
                            vsum_q     <= '0;
                            addr_q     <= BASE_A;
                            wcnt_q     <= '0;
                            n_q        <= word_count;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                            state_q    <= S_RECV_HI;
                        end
                    end
                end
                S_RECV_HI: begin
                    if (fire) begin
                        state_q <= S_RECV_LO;
                    end
                end
                S_RECV_LO: begin
                    if (word_vld) begin
                        in_ready_q    <= 1'b0;
                        mem_address_q <= addr_q;
                        mem_data_q    <= word;
                        state_q       <= S_WR_SETUP;
                    end
                end
                S_WR_SETUP: begin
                    checksum_q <= checksum_q + mem_data_q;
                    mem_wren_q <= 1'b1;
                    state_q    <= S_WR_STROBE;
                end
                S_WR_STROBE: begin
                    mem_wren_q <= 1'b0;
                    if (last_d) begin
                        wcnt_q        <= '0;
                        addr_q        <= BASE_A;
                        mem_address_q <= BASE_A;
                        mem_rden_q    <= 1'b1;
                        state_q       <= S_RD_ISSUE;
                    end else begin
                        wcnt_q     <= wcnt_d;
                        addr_q     <= addr_q + 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= S_RECV_HI;
                    end
                end
                S_RD_ISSUE: begin
                    mem_rden_q <= 1'b0;
                    wait_q     <= WAIT_LD;
                    state_q    <= (READ_LAT > 1) ? S_RD_WAIT : S_RD_CMP;
                end
                S_RD_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= S_RD_CMP;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_RD_CMP: begin
                    vsum_q <= vsum_d;
                    wcnt_q <= wcnt_d;
                    if (last_d) begin
                        busy_q <= 1'b0;
                        if (vsum_d == checksum_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_ERROR;
                        end
                    end else begin
                        addr_q        <= addr_q + 1'b1;
                        mem_address_q <= addr_q + 1'b1;
                        mem_rden_q    <= 1'b1;
                        state_q       <= S_RD_ISSUE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_wren    = mem_wren_q;
    assign bus.mem_rden    = mem_rden_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign checksum        = checksum_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: two instances (BASE_ADDR 1 and 0) each with a 512x16 RAM model.
module tb_mem_loader;
    import loader_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic [8:0] wc_a = '0, wc_b = '0;
    logic       busy_a, done_a, error_a, busy_b, done_b, error_b;
    logic [15:0] cks_a, cks_b;
    logic       ram_clear = 1'b1;
    logic       corrupt_a = 1'b0;

    mem_loader_if #(.ADDR_W(9), .DATA_W(16)) a_if ();
    mem_loader_if #(.ADDR_W(9), .DATA_W(16)) b_if ();

    mem_loader #(.ADDR_W(9), .DATA_W(16), .BASE_ADDR(1), .READ_LAT(2)) u_dut_a (
        .clock(clock), .reset(reset), .start(start_a), .word_count(wc_a), .bus(a_if),
        .busy(busy_a), .done(done_a), .error(error_a), .checksum(cks_a));

    mem_loader #(.ADDR_W(9), .DATA_W(16), .BASE_ADDR(0), .READ_LAT(2)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b), .word_count(wc_b), .bus(b_if),
        .busy(busy_b), .done(done_b), .error(error_b), .checksum(cks_b));

    // RAM models: write on wren, two-stage read pipeline
    logic [15:0] ram_a [512];
    logic [15:0] ram_b [512];
    logic [15:0] p1_a, p2_a, p1_b, p2_b;
    assign a_if.mem_q = p2_a;
    assign b_if.mem_q = p2_b;

    always @(posedge clock) begin
        if (ram_clear) begin
            for (int i = 0; i < 512; i++) begin
                ram_a[i] <= '0;
                ram_b[i] <= '0;
            end
        end else begin
            if (a_if.mem_wren) ram_a[a_if.mem_address] <= a_if.mem_data;
            if (b_if.mem_wren) ram_b[b_if.mem_address] <= b_if.mem_data;
        end
        if (a_if.mem_rden)
            p1_a <= ram_a[a_if.mem_address] ^ ((corrupt_a && a_if.mem_address == 9'd2) ? 16'h0001 : 16'h0000);
        if (b_if.mem_rden) p1_b <= ram_b[b_if.mem_address];
        p2_a <= p1_a;
        p2_b <= p1_b;
    end

    // Bus activity counters for instance A, sampled mid-cycle
    int wr_pulses_a = 0, wr_long_a = 0, wr_unstable_a = 0, rd_cycles_a = 0;
    int overlap_a = 0, rdy_bad_a = 0, wr_pulses_b = 0, rd_cycles_b = 0;
    logic        prev_wren_a = 1'b0;
    logic [8:0]  prev_addr_a = '0;
    logic [15:0] prev_data_a = '0;
    always @(negedge clock) begin
        if (a_if.mem_wren && !prev_wren_a) wr_pulses_a++;
        if (a_if.mem_wren && prev_wren_a) wr_long_a++;
        if (a_if.mem_wren && (a_if.mem_address != prev_addr_a || a_if.mem_data != prev_data_a)) wr_unstable_a++;
        if (a_if.mem_rden) rd_cycles_a++;
        if (a_if.mem_wren && a_if.mem_rden) overlap_a++;
        if (a_if.in_ready && (!busy_a || a_if.mem_wren || a_if.mem_rden)) rdy_bad_a++;
        if (b_if.mem_wren) wr_pulses_b++;
        if (b_if.mem_rden) rd_cycles_b++;
        prev_wren_a = a_if.mem_wren;
        prev_addr_a = a_if.mem_address;
        prev_data_a = a_if.mem_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one byte from a negedge; returns at the negedge after it transfers
    task automatic push_byte(input int sel, input logic [7:0] b, input bit gap);
        bit took = 1'b0;
        int guard = 0;
        if (sel == 0) begin a_if.in_valid = 1'b1; a_if.in_byte = b; end
        else          begin b_if.in_valid = 1'b1; b_if.in_byte = b; end
        while (!took && guard < 100) begin
            took = (sel == 0) ? a_if.in_ready : b_if.in_ready;
            @(posedge clock);
            @(negedge clock);
            guard++;
        end
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        if (!took) chk("byte_accept_timeout", 32'd0, 32'd1);
        if (gap) @(negedge clock);
    endtask

    task automatic pulse_start(input int sel, input logic [8:0] n);
        if (sel == 0) begin start_a = 1'b1; wc_a = n; end
        else          begin start_b = 1'b1; wc_b = n; end
        @(posedge clock);
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_end(input int sel, input int limit);
        int c = 0;
        while (c < limit && !((sel == 0) ? (done_a || error_a) : (done_b || error_b))) begin
            @(negedge clock);
            c++;
        end
        total++;
        assert (c < limit) else begin
            bad++;
            $error("FAIL end_timeout observed=%0d expected_below=%0d", c, limit);
        end
    endtask

    task automatic load3(input bit gap);
        push_byte(0, 8'h00, gap); push_byte(0, 8'h05, gap);
        push_byte(0, 8'hFF, gap); push_byte(0, 8'hFF, gap);
        push_byte(0, 8'h80, gap); push_byte(0, 8'h00, gap);
    endtask

    int s_wr, s_long, s_unst, s_rd, s_ovl, s_rdy, s_wrb, s_rdb;

    initial begin
        a_if.in_valid = 1'b0; a_if.in_byte = '0;
        b_if.in_valid = 1'b0; b_if.in_byte = '0;
        repeat (3) @(negedge clock);

        // Reset values
        chk("rst_in_ready", 32'(a_if.in_ready), 32'd0);
        chk("rst_wren_rden", {30'd0, a_if.mem_wren, a_if.mem_rden}, 32'd0);
        chk("rst_addr_data", {7'd0, a_if.mem_address, a_if.mem_data}, 32'd0);
        chk("rst_flags", {29'd0, busy_a, done_a, error_a}, 32'd0);
        chk("rst_checksum", 32'(cks_a), 32'd0);
        reset = 1'b0;
        ram_clear = 1'b0;
        @(negedge clock);

        // Reset asserted while the write strobe is high
        pulse_start(0, 9'd1);
        chk("busy_after_start", 32'(busy_a), 32'd1);
        push_byte(0, 8'hAA, 1'b0);
        push_byte(0, 8'h55, 1'b0);
        begin
            int g = 0;
            while (!a_if.mem_wren && g < 20) begin @(negedge clock); g++; end
        end
        chk("strobe_seen", 32'(a_if.mem_wren), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_outputs", {21'd0, a_if.in_ready, a_if.mem_wren, a_if.mem_rden, busy_a, done_a, error_a, 5'd0}, 32'd0);
        chk("midrst_addr_data", {7'd0, a_if.mem_address, a_if.mem_data}, 32'd0);
        chk("midrst_checksum", 32'(cks_a), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        pulse_start(0, 9'd1);
        push_byte(0, 8'h12, 1'b0);
        push_byte(0, 8'h34, 1'b0);
        wait_end(0, 50);
        chk("after_rst_ram1", 32'(ram_a[1]), 32'h1234);
        chk("after_rst_done", {30'd0, done_a, error_a}, 32'h2);

        // Three words, in_valid held high
        s_wr = wr_pulses_a; s_long = wr_long_a; s_unst = wr_unstable_a; s_ovl = overlap_a; s_rdy = rdy_bad_a;
        pulse_start(0, 9'd3);
        load3(1'b0);
        wait_end(0, 100);
        chk("held_ram1", 32'(ram_a[1]), 32'h0005);
        chk("held_ram2", 32'(ram_a[2]), 32'hFFFF);
        chk("held_ram3", 32'(ram_a[3]), 32'h8000);
        chk("held_checksum", 32'(cks_a), 32'h8004);
        chk("held_wren_pulses", 32'(wr_pulses_a - s_wr), 32'd3);
        chk("held_wren_single", 32'(wr_long_a - s_long), 32'd0);
        chk("held_addr_stable", 32'(wr_unstable_a - s_unst), 32'd0);
        chk("held_no_overlap", 32'(overlap_a - s_ovl), 32'd0);
        chk("held_flags", {29'd0, busy_a, done_a, error_a}, 32'h2);

        // Same load, in_valid toggling, RAM cleared first
        ram_clear = 1'b1;
        @(negedge clock);
        ram_clear = 1'b0;
        pulse_start(0, 9'd3);
        load3(1'b1);
        wait_end(0, 150);
        chk("toggle_ram1", 32'(ram_a[1]), 32'h0005);
        chk("toggle_ram2", 32'(ram_a[2]), 32'hFFFF);
        chk("toggle_ram3", 32'(ram_a[3]), 32'h8000);
        chk("toggle_checksum", 32'(cks_a), 32'h8004);
        chk("toggle_done", {29'd0, busy_a, done_a, error_a}, 32'h2);
        chk("ready_only_recv", 32'(rdy_bad_a - s_rdy), 32'd0);

        // Corrupted readback of RAM[2]
        corrupt_a = 1'b1;
        pulse_start(0, 9'd3);
        load3(1'b0);
        wait_end(0, 100);
        chk("corrupt_flags", {29'd0, busy_a, done_a, error_a}, 32'h1);
        corrupt_a = 1'b0;

        // Range errors: no RAM traffic at all
        s_wr = wr_pulses_a; s_rd = rd_cycles_a;
        pulse_start(0, 9'd0);
        chk("n0_flags", {29'd0, busy_a, done_a, error_a}, 32'h1);
        pulse_start(0, 9'd511);
        chk("n511_base1_flags", {29'd0, busy_a, done_a, error_a}, 32'h1);
        repeat (5) @(negedge clock);
        chk("range_no_wren", 32'(wr_pulses_a - s_wr), 32'd0);
        chk("range_no_rden", 32'(rd_cycles_a - s_rd), 32'd0);

        // Full 511-word load at base 0: word i = i
        s_wrb = wr_pulses_b; s_rdb = rd_cycles_b;
        pulse_start(1, 9'd511);
        for (int i = 0; i < 511; i++) begin
            logic [15:0] w;
            w = 16'(i);
            push_byte(1, w[15:8], 1'b0);
            push_byte(1, w[7:0], 1'b0);
        end
        wait_end(1, 4000);
        chk("n511_base0_flags", {29'd0, busy_b, done_b, error_b}, 32'h2);
        chk("n511_checksum", 32'(cks_b), 32'hFD01);
        chk("n511_ram0", 32'(ram_b[0]), 32'h0000);
        chk("n511_ram255", 32'(ram_b[255]), 32'h00FF);
        chk("n511_ram510", 32'(ram_b[510]), 32'h01FE);
        chk("n511_wren", 32'(wr_pulses_b - s_wrb), 32'd511);
        chk("n511_rden", 32'(rd_cycles_b - s_rdb), 32'd511);

        // Start pulsed mid-load is ignored
        ram_clear = 1'b1;
        @(negedge clock);
        ram_clear = 1'b0;
        s_wr = wr_pulses_a;
        pulse_start(0, 9'd2);
        push_byte(0, 8'hAB, 1'b0);
        pulse_start(0, 9'd5);
        push_byte(0, 8'hCD, 1'b0);
        push_byte(0, 8'h12, 1'b0);
        pulse_start(0, 9'd0);
        push_byte(0, 8'h34, 1'b0);
        wait_end(0, 100);
        chk("busy_start_ram1", 32'(ram_a[1]), 32'hABCD);
        chk("busy_start_ram2", 32'(ram_a[2]), 32'h1234);
        chk("busy_start_ram3", 32'(ram_a[3]), 32'h0000);
        chk("busy_start_checksum", 32'(cks_a), 32'hBE01);
        chk("busy_start_wren", 32'(wr_pulses_a - s_wr), 32'd2);
        chk("busy_start_flags", {29'd0, busy_a, done_a, error_a}, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
